core_harness_controller: RTL and testbench

- Host-side controller that hosts a soft core under test.
- Owns the unified word memory, serving both the core's instruction port and its data port.
- Owns the core's clock enable and reset.
- Takes host commands over an 8N1 UART, which it uses to load and inspect memory and to start and stop the core.

---
 rtl/core_harness_controller.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 tb/tb_core_harness_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_harness_controller.sv
// Host-side harness: UART command interface, unified word memory and clock/reset control for a soft core.
// Define CORE_STEP_EN to add the 'P' command, which runs the core for a counted number of clock edges.
module core_harness_controller #(
  parameter int unsigned CLK_FREQ         = 100000000,
  parameter int unsigned BIT_RATE         = 115200,
  parameter int unsigned BUS_WIDTH        = 32,
  parameter logic [31:0] ID               = 32'h0,
  parameter int unsigned RESET_CLK_CYCLES = 20,
  parameter int unsigned MEMORY_SIZE      = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic                 tx,
  output logic                 clk_core,
  output logic                 reset_core,
  input  logic                 core_read_memory,
  input  logic [BUS_WIDTH-1:0] core_address_memory,
  output logic [BUS_WIDTH-1:0] core_read_data_memory,
  input  logic                 core_read_memory_data,
  input  logic                 core_write_memory_data,
  input  logic [BUS_WIDTH-1:0] core_address_memory_data,
  input  logic [BUS_WIDTH-1:0] core_write_data_memory_data,
  output logic [BUS_WIDTH-1:0] core_read_data_memory_data,
  output logic                 core_memory_response_data
);

  localparam int unsigned DIVISOR   = CLK_FREQ / BIT_RATE;
  localparam int unsigned CNT_W     = $clog2(DIVISOR + 1);
  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIVISOR - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIVISOR / 2 - 1);
  localparam int unsigned MEM_WORDS = MEMORY_SIZE / 4;
  localparam int unsigned IDX_W     = $clog2(MEM_WORDS);
  localparam int unsigned RST_W     = (RESET_CLK_CYCLES < 2) ? 1 : $clog2(RESET_CLK_CYCLES + 1);

  localparam logic [7:0] OP_W = 8'h57;
  localparam logic [7:0] OP_R = 8'h52;
  localparam logic [7:0] OP_S = 8'h53;
  localparam logic [7:0] OP_H = 8'h48;
  localparam logic [7:0] OP_I = 8'h49;
  localparam logic [7:0] OP_P = 8'h50;
  localparam logic [7:0] CH_K = 8'h4B;
  localparam logic [7:0] CH_E = 8'h45;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [1:0] {IDLE, GET_ARGS, EXEC, REPLY} state_t;

  // ---------------- UART receive ----------------
  logic            rx_meta_reg, rx_sync_reg, rx_prev_reg;
  rx_state_t       rx_state_reg, rx_state_next;
  logic [CNT_W-1:0] rx_cnt_reg, rx_cnt_next;
  logic [2:0]      rx_bit_reg, rx_bit_next;
  logic [7:0]      rx_shift_reg, rx_shift_next;
  logic            rx_valid_reg, rx_valid_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_reg  <= 1'b1;
      rx_sync_reg  <= 1'b1;
      rx_prev_reg  <= 1'b1;
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
      rx_valid_reg <= 1'b0;
    end else begin
      rx_meta_reg  <= rx;
      rx_sync_reg  <= rx_meta_reg;
      rx_prev_reg  <= rx_sync_reg;
      rx_state_reg <= rx_state_next;
      rx_cnt_reg   <= rx_cnt_next;
      rx_bit_reg   <= rx_bit_next;
      rx_shift_reg <= rx_shift_next;
      rx_valid_reg <= rx_valid_next;
    end
  end

  always_comb begin
    rx_state_next = rx_state_reg;
    rx_cnt_next   = rx_cnt_reg;
    rx_bit_next   = rx_bit_reg;
    rx_shift_next = rx_shift_reg;
    rx_valid_next = 1'b0;
    case (rx_state_reg)
      RX_IDLE: begin
        if (rx_prev_reg && !rx_sync_reg) begin
          rx_state_next = RX_START;
          rx_cnt_next   = '0;
        end
      end
      RX_START: begin
        // Mid-bit recheck rejects glitches shorter than half a bit.
        if (rx_cnt_reg == HALF_LAST) begin
          rx_cnt_next   = '0;
          rx_bit_next   = '0;
          rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_reg == DIV_LAST) begin
          rx_cnt_next   = '0;
          rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
          rx_bit_next   = rx_bit_reg + 1'b1;
          if (rx_bit_reg == 3'd7) rx_state_next = RX_STOP;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_reg == DIV_LAST) begin
          rx_state_next = RX_IDLE;
          rx_valid_next = rx_sync_reg;
        end else begin
          rx_cnt_next = rx_cnt_reg + 1'b1;
        end
      end
      default: rx_state_next = RX_IDLE;
    endcase
  end

  // ---------------- UART transmit ----------------
  logic             tx_load;
  logic [31:0]      tx_data;
  logic             tx_four;
  logic             tx_busy_reg;
  logic [9:0]       tx_frame_reg;
  logic [23:0]      tx_buf_reg;
  logic [1:0]       tx_left_reg;
  logic [3:0]       tx_bit_reg;
  logic [CNT_W-1:0] tx_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_busy_reg  <= 1'b0;
      tx_frame_reg <= '1;
      tx_buf_reg   <= '0;
      tx_left_reg  <= '0;
      tx_bit_reg   <= '0;
      tx_cnt_reg   <= '0;
    end else if (tx_load) begin
      tx_busy_reg  <= 1'b1;
      tx_frame_reg <= {1'b1, tx_data[31:24], 1'b0};
      tx_buf_reg   <= tx_data[23:0];
      tx_left_reg  <= tx_four ? 2'd3 : 2'd0;
      tx_bit_reg   <= '0;
      tx_cnt_reg   <= '0;
    end else if (tx_busy_reg) begin
      if (tx_cnt_reg == DIV_LAST) begin
        tx_cnt_reg <= '0;
        if (tx_bit_reg == 4'd9) begin
          if (tx_left_reg == 2'd0) begin
            tx_busy_reg <= 1'b0;
          end else begin
            tx_frame_reg <= {1'b1, tx_buf_reg[23:16], 1'b0};
            tx_buf_reg   <= {tx_buf_reg[15:0], 8'h00};
            tx_left_reg  <= tx_left_reg - 1'b1;
            tx_bit_reg   <= '0;
          end
        end else begin
          tx_frame_reg <= {1'b1, tx_frame_reg[9:1]};
          tx_bit_reg   <= tx_bit_reg + 1'b1;
        end
      end else begin
        tx_cnt_reg <= tx_cnt_reg + 1'b1;
      end
    end
  end

  assign tx = tx_busy_reg ? tx_frame_reg[0] : 1'b1;

  // ---------------- Command FSM ----------------
  state_t           state_reg, state_next;
  logic [7:0]       op_reg, op_next;
  logic [3:0]       arg_cnt_reg, arg_cnt_next;
  logic [63:0]      args_reg, args_next;
  logic             phase_reg, phase_next;
  logic             run_reg, run_next;
  logic             rcore_reg, rcore_next;
  logic [RST_W-1:0] rst_cnt_reg, rst_cnt_next;
  logic             clk_en_neg_reg;
  logic             host_we, host_re;
  logic [31:0]      data_rd_reg;
`ifdef CORE_STEP_EN
  logic [31:0]      step_cnt_reg, step_cnt_next;
`endif

  function automatic logic [3:0] arg_bytes(input logic [7:0] op);
    case (op)
      OP_W:    return 4'd8;
      OP_R:    return 4'd4;
`ifdef CORE_STEP_EN
      OP_P:    return 4'd4;
`endif
      default: return 4'd0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      op_reg      <= '0;
      arg_cnt_reg <= '0;
      args_reg    <= '0;
      phase_reg   <= 1'b0;
      run_reg     <= 1'b0;
      rcore_reg   <= 1'b1;
      rst_cnt_reg <= '0;
`ifdef CORE_STEP_EN
      step_cnt_reg <= '0;
`endif
    end else begin
      state_reg   <= state_next;
      op_reg      <= op_next;
      arg_cnt_reg <= arg_cnt_next;
      args_reg    <= args_next;
      phase_reg   <= phase_next;
      run_reg     <= run_next;
      rcore_reg   <= rcore_next;
      rst_cnt_reg <= rst_cnt_next;
`ifdef CORE_STEP_EN
      step_cnt_reg <= step_cnt_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    op_next      = op_reg;
    arg_cnt_next = arg_cnt_reg;
    args_next    = args_reg;
    phase_next   = phase_reg;
    run_next     = run_reg;
    rcore_next   = rcore_reg;
    rst_cnt_next = rst_cnt_reg;
    tx_load      = 1'b0;
    tx_data      = '0;
    tx_four      = 1'b0;
    host_we      = 1'b0;
    host_re      = 1'b0;
`ifdef CORE_STEP_EN
    step_cnt_next = step_cnt_reg;
    // clk_en_neg_reg is the enable gating the clk_core edge at this clk edge.
    if (step_cnt_reg != 32'd0 && clk_en_neg_reg) begin
      step_cnt_next = step_cnt_reg - 32'd1;
      if (step_cnt_reg == 32'd1) run_next = 1'b0;
    end
`endif
    if (rst_cnt_reg != '0) begin
      rst_cnt_next = rst_cnt_reg - 1'b1;
      if (rst_cnt_reg == RST_W'(1)) rcore_next = 1'b0;
    end

    case (state_reg)
      IDLE: begin
        if (rx_valid_reg) begin
          op_next      = rx_shift_reg;
          arg_cnt_next = '0;
          phase_next   = 1'b0;
          state_next   = (arg_bytes(rx_shift_reg) == 4'd0) ? EXEC : GET_ARGS;
        end
      end
      GET_ARGS: begin
        if (rx_valid_reg) begin
          args_next    = {args_reg[55:0], rx_shift_reg};
          arg_cnt_next = arg_cnt_reg + 4'd1;
          if (arg_cnt_reg + 4'd1 == arg_bytes(op_reg)) state_next = EXEC;
        end
      end
      EXEC: begin
        case (op_reg)
          OP_W: begin
            host_we    = !run_reg;
            tx_load    = 1'b1;
            tx_data    = {run_reg ? CH_E : CH_K, 24'h0};
            state_next = REPLY;
          end
          OP_R: begin
            if (run_reg) begin
              tx_load    = 1'b1;
              tx_data    = {CH_E, 24'h0};
              state_next = REPLY;
            end else if (!phase_reg) begin
              host_re    = 1'b1;
              phase_next = 1'b1;
            end else begin
              tx_load    = 1'b1;
              tx_data    = data_rd_reg;
              tx_four    = 1'b1;
              phase_next = 1'b0;
              state_next = REPLY;
            end
          end
          OP_S: begin
            run_next     = 1'b1;
            rcore_next   = (RESET_CLK_CYCLES != 0);
            rst_cnt_next = RST_W'(RESET_CLK_CYCLES);
`ifdef CORE_STEP_EN
            step_cnt_next = '0;
`endif
            tx_load      = 1'b1;
            tx_data      = {CH_K, 24'h0};
            state_next   = REPLY;
          end
          OP_H: begin
            run_next     = 1'b0;
            rcore_next   = 1'b1;
            rst_cnt_next = '0;
`ifdef CORE_STEP_EN
            step_cnt_next = '0;
`endif
            tx_load      = 1'b1;
            tx_data      = {CH_K, 24'h0};
            state_next   = REPLY;
          end
          OP_I: begin
            tx_load    = 1'b1;
            tx_data    = ID;
            tx_four    = 1'b1;
            state_next = REPLY;
          end
`ifdef CORE_STEP_EN
          OP_P: begin
            if (!phase_reg) begin
              if (args_reg[31:0] == 32'd0) begin
                tx_load    = 1'b1;
                tx_data    = {CH_K, 24'h0};
                state_next = REPLY;
              end else begin
                run_next      = 1'b1;
                rcore_next    = 1'b0;
                rst_cnt_next  = '0;
                step_cnt_next = args_reg[31:0];
                phase_next    = 1'b1;
              end
            end else if (!run_reg) begin
              phase_next = 1'b0;
              tx_load    = 1'b1;
              tx_data    = {CH_K, 24'h0};
              state_next = REPLY;
            end
          end
`endif
          default: begin
            tx_load    = 1'b1;
            tx_data    = {CH_E, 24'h0};
            state_next = REPLY;
          end
        endcase
      end
      REPLY: begin
        // Incoming bytes are ignored until the whole reply has left.
        if (!tx_busy_reg) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Enable changes only while clk is low, so the AND gate cannot glitch.
  always_ff @(negedge clk) begin
    if (reset) clk_en_neg_reg <= 1'b0;
    else       clk_en_neg_reg <= run_reg;
  end

  assign clk_core   = clk & clk_en_neg_reg;
  assign reset_core = rcore_reg;

  // ---------------- Unified memory ----------------
  logic [31:0]      mem [MEM_WORDS];
  logic [31:0]      host_addr;
  logic [IDX_W-1:0] instr_idx, port_idx;
  logic             core_we, core_re, port_we, port_re;
  logic [31:0]      port_wdata;
  logic [31:0]      instr_rd_reg;
  logic             resp_reg;
  logic             unused_ok;

  // The core drives the data port only while running; otherwise the host owns it.
  assign host_addr  = (op_reg == OP_W) ? args_reg[63:32] : args_reg[31:0];
  assign instr_idx  = core_address_memory[IDX_W+1:2];
  assign core_we    = run_reg & core_write_memory_data;
  assign core_re    = run_reg & core_read_memory_data;
  assign port_we    = core_we | host_we;
  assign port_re    = core_re | host_re;
  assign port_idx   = run_reg ? core_address_memory_data[IDX_W+1:2] : host_addr[IDX_W+1:2];
  assign port_wdata = run_reg ? core_write_data_memory_data : args_reg[31:0];
  assign unused_ok  = ^{core_address_memory[BUS_WIDTH-1:IDX_W+2], core_address_memory[1:0],
                        core_address_memory_data[BUS_WIDTH-1:IDX_W+2], core_address_memory_data[1:0],
                        host_addr[31:IDX_W+2], host_addr[1:0]};

  always_ff @(posedge clk) begin
    if (port_we) mem[port_idx] <= port_wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_rd_reg <= '0;
      data_rd_reg  <= '0;
      resp_reg     <= 1'b0;
    end else begin
      if (run_reg && core_read_memory) instr_rd_reg <= mem[instr_idx];
      // A simultaneous write lands after this read, so the old word is returned.
      if (port_re) data_rd_reg <= mem[port_idx];
      resp_reg <= core_we | core_re;
    end
  end

  assign core_read_data_memory      = instr_rd_reg;
  assign core_read_data_memory_data = data_rd_reg;
  assign core_memory_response_data  = resp_reg;

endmodule

// File: tb/tb_core_harness_controller.sv
// Directed bench for core_harness_controller: UART commands, core memory port and clock/reset control.
module tb_core_harness_controller;

  localparam int DIV = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx = 1'b1;
  logic        tx, clk_core, reset_core;
  logic        core_read_memory = 1'b0;
  logic [31:0] core_address_memory = '0;
  logic [31:0] core_read_data_memory;
  logic        core_read_memory_data = 1'b0;
  logic        core_write_memory_data = 1'b0;
  logic [31:0] core_address_memory_data = '0;
  logic [31:0] core_write_data_memory_data = '0;
  logic [31:0] core_read_data_memory_data;
  logic        core_memory_response_data;

  core_harness_controller #(
    .CLK_FREQ(1000000), .BIT_RATE(100000), .BUS_WIDTH(32), .ID(32'h0),
    .RESET_CLK_CYCLES(20), .MEMORY_SIZE(4096)
  ) dut (
    .clk(clk), .reset(reset), .rx(rx), .tx(tx), .clk_core(clk_core), .reset_core(reset_core),
    .core_read_memory(core_read_memory), .core_address_memory(core_address_memory),
    .core_read_data_memory(core_read_data_memory),
    .core_read_memory_data(core_read_memory_data), .core_write_memory_data(core_write_memory_data),
    .core_address_memory_data(core_address_memory_data),
    .core_write_data_memory_data(core_write_data_memory_data),
    .core_read_data_memory_data(core_read_data_memory_data),
    .core_memory_response_data(core_memory_response_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0] rxq[$];
  int core_edges = 0;
  int rst_edges = 0;
  logic rst_prev = 1'b1;

  // UART receiver model: samples each bit near its middle.
  always begin
    logic [7:0] b;
    @(negedge tx);
    repeat (DIV / 2) @(negedge clk);
    if (tx == 1'b0) begin
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(negedge clk);
        b[i] = tx;
      end
      repeat (DIV) @(negedge clk);
      if (tx === 1'b1) rxq.push_back(b);
    end
  end

  // clk_core edge counter; rst_prev holds reset_core as seen by the core at that edge.
  always @(posedge clk) begin
    #1;
    if (clk_core === 1'b1) begin
      core_edges++;
      if (rst_prev) rst_edges++;
    end
    rst_prev = reset_core;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic expect_bytes(input string tag, input logic [31:0] exp, input int n);
    int waited;
    logic [7:0] o;
    waited = 0;
    while (rxq.size() < n && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    for (int i = 0; i < n; i++) begin
      o = 8'hxx;
      if (rxq.size() > 0) o = rxq.pop_front();
      check($sformatf("%s_b%0d", tag, i), {24'h0, o}, {24'h0, exp[8*(n-1-i) +: 8]});
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic sample;
    @(posedge clk);
    #1;
  endtask

  int e0, r0;

  initial begin
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (3) sample();
    check("rst_tx", tx, 1);
    check("rst_reset_core", reset_core, 1);
    check("rst_clk_core", clk_core, 0);
    check("rst_resp", core_memory_response_data, 0);
    check("rst_instr_data", core_read_data_memory, 0);
    check("rst_data_data", core_read_data_memory_data, 0);

    send_byte(8'h57); send_word(32'h00000010); send_word(32'hDEADBEEF);
    expect_bytes("w10", 32'h4B, 1);
    send_byte(8'h52); send_word(32'h00000010);
    expect_bytes("r10", 32'hDEADBEEF, 4);

    send_byte(8'h57); send_word(32'h00001010); send_word(32'h12345678);
    expect_bytes("w1010", 32'h4B, 1);
    send_byte(8'h52); send_word(32'h00000010);
    expect_bytes("r10_wrap", 32'h12345678, 4);

    e0 = core_edges; r0 = rst_edges;
    send_byte(8'h53);
    expect_bytes("start", 32'h4B, 1);
    check("start_reset_edges", rst_edges - r0, 20);
    check("start_clk_core_runs", ((core_edges - e0) > 20) ? 1 : 0, 1);
    sample();
    check("start_reset_low", reset_core, 0);

    @(negedge clk);
    core_write_memory_data = 1'b1;
    core_address_memory_data = 32'h20;
    core_write_data_memory_data = 32'hCAFEF00D;
    check("core_wr_resp_before", core_memory_response_data, 0);
    sample();
    check("core_wr_resp", core_memory_response_data, 1);
    @(negedge clk);
    core_write_memory_data = 1'b0;
    sample();
    check("core_resp_one_cycle", core_memory_response_data, 0);

    @(negedge clk);
    core_read_memory_data = 1'b1; core_address_memory_data = 32'h10;
    core_read_memory = 1'b1; core_address_memory = 32'h1010;
    sample();
    check("core_data_rd", core_read_data_memory_data, 32'h12345678);
    check("core_instr_rd_wrap", core_read_data_memory, 32'h12345678);
    check("core_rd_resp", core_memory_response_data, 1);
    @(negedge clk);
    core_read_memory_data = 1'b0; core_read_memory = 1'b0;
    core_write_memory_data = 1'b1; core_address_memory_data = 32'h30;
    core_write_data_memory_data = 32'hAAAA5555;
    @(negedge clk);
    core_read_memory_data = 1'b1;
    core_write_data_memory_data = 32'h0BADF00D;
    sample();
    check("core_rw_old_word", core_read_data_memory_data, 32'hAAAA5555);
    @(negedge clk);
    core_read_memory_data = 1'b0; core_write_memory_data = 1'b0;

    send_byte(8'h57); send_word(32'h00000040); send_word(32'h11111111);
    expect_bytes("w_running", 32'h45, 1);
    send_byte(8'h48);
    expect_bytes("halt", 32'h4B, 1);
    sample();
    check("halt_reset_core", reset_core, 1);
    e0 = core_edges;
    repeat (30) sample();
    check("halt_clk_stopped", core_edges - e0, 0);
    send_byte(8'h52); send_word(32'h00000020);
    expect_bytes("r20", 32'hCAFEF00D, 4);
    send_byte(8'h52); send_word(32'h00000030);
    expect_bytes("r30", 32'h0BADF00D, 4);

    send_byte(8'h5A);
    expect_bytes("unknown", 32'h45, 1);
    send_byte(8'h49);
    expect_bytes("id", 32'h00000000, 4);

`ifdef CORE_STEP_EN
    e0 = core_edges;
    send_byte(8'h50); send_word(32'h00000005);
    expect_bytes("step5", 32'h4B, 1);
    check("step5_edges", core_edges - e0, 5);
    check("step5_reset_core", reset_core, 0);
    e0 = core_edges;
    send_byte(8'h50); send_word(32'h00000000);
    expect_bytes("step0", 32'h4B, 1);
    check("step0_edges", core_edges - e0, 0);
`else
    send_byte(8'h50);
    expect_bytes("p_unknown", 32'h45, 1);
`endif

    send_byte(8'h53);
    expect_bytes("restart", 32'h4B, 1);
    send_byte(8'h57); send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sample();
    check("abort_reset_core", reset_core, 1);
    check("abort_tx_idle", tx, 1);
    e0 = core_edges;
    repeat (10) sample();
    check("abort_clk_stopped", core_edges - e0, 0);
    send_byte(8'h52); send_word(32'h00000010);
    expect_bytes("abort_r10_kept", 32'h12345678, 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: observed no finish expected finish before timeout");
    $fatal(1, "timeout");
  end

endmodule
